// File: rtl/pipe_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
// Holds the Controller bundle, the ID/EX record and the all-zero bubble values.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 9;
    localparam int DEF_RA_W   = 5;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] ALUOp;
        logic       Branch;
    } ctrl_t;

    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] rd1;
        logic [DEF_DATA_W-1:0] rd2;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_RA_W-1:0]   rs1;
        logic [DEF_RA_W-1:0]   rs2;
        logic [DEF_RA_W-1:0]   rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
    } id_ex_t;

    localparam ctrl_t  CTRL_NOP     = '0;
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    output logic            hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush bubbles
// and saturating stall/flush event counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUOp,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic [1:0]        ex_ALUOp,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [RA_W-1:0]   ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Same layout as id_ex_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } stage_t;

    localparam stage_t           STAGE_BUBBLE = '0;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    stage_t ex_q;
    stage_t id_d;
    logic   hazard;

    hazard_detect #(
        .RA_W(RA_W)
    ) u_hazard_detect (
        .ex_valid   (ex_q.valid),
        .ex_mem_read(ex_q.ctrl.MemRead),
        .ex_rd      (ex_q.rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .hazard     (hazard)
    );

    // A flushed ID instruction is wrong-path, so it must never hold up fetch.
    assign stall = reset && hazard && !flush;

    always_comb begin
        id_d                = STAGE_BUBBLE;
        id_d.valid          = id_valid;
        id_d.ctrl.ALUSrc    = id_ALUSrc;
        id_d.ctrl.MemtoReg  = id_MemtoReg;
        id_d.ctrl.RegWrite  = id_RegWrite;
        id_d.ctrl.MemRead   = id_MemRead;
        id_d.ctrl.MemWrite  = id_MemWrite;
        id_d.ctrl.ALUOp     = id_ALUOp;
        id_d.ctrl.Branch    = id_Branch;
        id_d.pc             = id_pc;
        id_d.rd1            = id_rd1;
        id_d.rd2            = id_rd2;
        id_d.imm            = id_imm;
        id_d.rs1            = id_rs1;
        id_d.rs2            = id_rs2;
        id_d.rd             = id_rd;
        id_d.funct3         = id_funct3;
        id_d.funct7         = id_funct7;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q <= STAGE_BUBBLE;
        end else if (flush || hazard) begin
            ex_q <= STAGE_BUBBLE;
        end else begin
            ex_q <= id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_ALUSrc   = ex_q.ctrl.ALUSrc;
    assign ex_MemtoReg = ex_q.ctrl.MemtoReg;
    assign ex_RegWrite = ex_q.ctrl.RegWrite;
    assign ex_MemRead  = ex_q.ctrl.MemRead;
    assign ex_MemWrite = ex_q.ctrl.MemWrite;
    assign ex_Branch   = ex_q.ctrl.Branch;
    assign ex_ALUOp    = ex_q.ctrl.ALUOp;
    assign ex_pc       = ex_q.pc;
    assign ex_rd1      = ex_q.rd1;
    assign ex_rd2      = ex_q.rd2;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7   = ex_q.funct7;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage, checked against a
// cycle-level model of the EX slot and the saturating counters.
module tb_id_ex_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]  id_ALUOp;
    logic [8:0]  id_pc;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        flush;
    logic        ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]  ex_ALUOp;
    logic [8:0]  ex_pc;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic        valid, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0]  aluop;
        logic [8:0]  pc;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } slot_t;

    slot_t expEx;
    int    expStallCnt = 0;
    int    expFlushCnt = 0;
    int    passCount   = 0;
    int    totalCount  = 0;

    id_ex_stage #(
        .DATA_W(32), .PC_W(9), .RA_W(5), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
        .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush),
        .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic slot_t emptySlot();
        slot_t s;
        s.valid = 0; s.alusrc = 0; s.memtoreg = 0; s.regwrite = 0; s.memread = 0;
        s.memwrite = 0; s.branch = 0; s.aluop = 0; s.pc = 0; s.rd1 = 0; s.rd2 = 0;
        s.imm = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.f3 = 0; s.f7 = 0;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic setInstr(input logic v, input logic mr, input logic rw, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] op);
        id_valid = v; id_MemRead = mr; id_RegWrite = rw; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = a; id_rd2 = b; id_ALUOp = op;
        id_ALUSrc = mr; id_MemtoReg = mr; id_MemWrite = 0; id_Branch = 0;
        id_pc = 9'h004; id_imm = 32'h0; id_funct3 = mr ? 3'b010 : 3'b000; id_funct7 = 7'h00;
    endtask

    task automatic randomInputs();
        id_valid = ($urandom_range(0, 3) != 0);
        {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemWrite, id_Branch} = 5'($urandom);
        id_MemRead = $urandom_range(0, 1) == 1;
        id_ALUOp = 2'($urandom); id_pc = 9'($urandom);
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
    endtask

    // One clock: apply reset/flush, check stall, advance the model, check EX.
    task automatic applyStimulus(input logic rstN, input logic fl);
        logic  hz, expStall;
        slot_t nxt;
        reset = rstN; flush = fl;
        #1;
        hz = expEx.valid && expEx.memread && (expEx.rd != 0) && id_valid &&
             ((id_rs1 == expEx.rd) || (id_rs2 == expEx.rd));
        expStall = rstN && hz && !fl;
        checkOutput("stall", 128'(stall), 128'(expStall));
        nxt = emptySlot();
        if (!rstN) begin
            expStallCnt = 0; expFlushCnt = 0;
        end else begin
            if (expStall && expStallCnt < CNT_MAX) expStallCnt++;
            if (fl && expFlushCnt < CNT_MAX) expFlushCnt++;
            if (!(fl || hz)) begin
                nxt.valid = id_valid; nxt.alusrc = id_ALUSrc; nxt.memtoreg = id_MemtoReg;
                nxt.regwrite = id_RegWrite; nxt.memread = id_MemRead; nxt.memwrite = id_MemWrite;
                nxt.branch = id_Branch; nxt.aluop = id_ALUOp; nxt.pc = id_pc; nxt.rd1 = id_rd1;
                nxt.rd2 = id_rd2; nxt.imm = id_imm; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
                nxt.rd = id_rd; nxt.f3 = id_funct3; nxt.f7 = id_funct7;
            end
        end
        @(posedge clk);
        #1;
        expEx = nxt;
        checkOutput("ctrl", 128'({ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                                  ex_MemWrite, ex_ALUOp, ex_Branch}),
                    128'({expEx.valid, expEx.alusrc, expEx.memtoreg, expEx.regwrite, expEx.memread,
                          expEx.memwrite, expEx.aluop, expEx.branch}));
        checkOutput("data", 128'({ex_rd1, ex_rd2, ex_imm}), 128'({expEx.rd1, expEx.rd2, expEx.imm}));
        checkOutput("addr", 128'({ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}),
                    128'({expEx.pc, expEx.rs1, expEx.rs2, expEx.rd, expEx.f3, expEx.f7}));
        checkOutput("stall_cnt", 128'(stall_cnt), 128'(expStallCnt));
        checkOutput("flush_cnt", 128'(flush_cnt), 128'(expFlushCnt));
    endtask

    initial begin
        expEx = emptySlot();
        reset = 0; flush = 0;
        setInstr(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset state");
        applyStimulus(0, 0);
        checkOutput("reset_valid", 128'(ex_valid), 128'(0));

        $display("[TB] pass-through add");
        setInstr(1, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 2'b10);
        applyStimulus(1, 0);
        checkOutput("pt_rd1_rd2", 128'({ex_rd1, ex_rd2, ex_rd}), 128'({32'd5, 32'd7, 5'd3}));

        $display("[TB] load-use stall");
        setInstr(1, 1, 1, 5'd1, 5'd0, 5'd5, 0, 0, 2'b00);
        applyStimulus(1, 0);
        setInstr(1, 0, 1, 5'd6, 5'd5, 5'd7, 32'd11, 32'd13, 2'b10);
        applyStimulus(1, 0);
        checkOutput("lu_bubble", 128'({ex_valid, ex_MemRead, ex_RegWrite}), 128'(0));
        applyStimulus(1, 0);
        checkOutput("lu_replay", 128'({ex_valid, ex_rd, stall_cnt}), 128'({1'b1, 5'd7, 4'd1}));

        $display("[TB] load to x0");
        setInstr(1, 1, 1, 5'd2, 5'd0, 5'd0, 0, 0, 2'b00);
        applyStimulus(1, 0);
        setInstr(1, 0, 1, 5'd0, 5'd0, 5'd4, 32'd1, 32'd2, 2'b10);
        applyStimulus(1, 0);
        checkOutput("x0_loaded", 128'({ex_valid, ex_rd}), 128'({1'b1, 5'd4}));

        $display("[TB] flush over hazard");
        applyStimulus(0, 0);
        setInstr(1, 1, 1, 5'd1, 5'd0, 5'd5, 0, 0, 2'b00);
        applyStimulus(1, 0);
        setInstr(1, 0, 1, 5'd5, 5'd5, 5'd8, 32'd3, 32'd4, 2'b10);
        applyStimulus(1, 1);
        checkOutput("fl_counts", 128'({flush_cnt, stall_cnt, ex_valid}), 128'({4'd1, 4'd0, 1'b0}));

        $display("[TB] reset during stall");
        setInstr(1, 1, 1, 5'd1, 5'd0, 5'd5, 0, 0, 2'b00);
        applyStimulus(1, 0);
        setInstr(1, 0, 1, 5'd5, 5'd2, 5'd9, 3, 4, 2'b10);
        applyStimulus(0, 0);
        setInstr(0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 2'b00);
        applyStimulus(1, 0);

        $display("[TB] flush counter saturation");
        for (int i = 0; i < 20; i++) begin
            randomInputs();
            applyStimulus(1, 1);
        end
        checkOutput("fl_sat", 128'(flush_cnt), 128'(15));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            randomInputs();
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
